// File: rtl/block_raster_reader.sv
// Block-raster AXI frame reader: one INCR burst per block line, several bursts in flight,
// every returned beat tagged with its in-block pixel and block coordinates.
module block_raster_reader #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned BLOCK_W         = 8,
  parameter int unsigned BLOCK_H         = 8,
  parameter int unsigned BPP             = 1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_ready,
  input  logic [15:0]           frame_width,
  input  logic [15:0]           frame_height,
  input  logic [15:0]           line_stride,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  output logic                  arvalid,
  output logic [ADDR_WIDTH-1:0] araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  rready,
  output logic                  pixel_valid,
  output logic [5:0]            pixel_x,
  output logic [5:0]            pixel_y,
  output logic [15:0]           block_col,
  output logic [15:0]           block_row,
  output logic                  start_of_frame,
  output logic                  end_of_block,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] base_addr_out,
  output logic                  busy,
  output logic                  cfg_error
);

  localparam int unsigned XW     = $clog2(BLOCK_W);
  localparam int unsigned YW     = $clog2(BLOCK_H);
  localparam int unsigned BPP_SH = $clog2(BPP);
  localparam int unsigned OW     = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(BLOCK_W * BPP);
  localparam logic [OW-1:0]         MAX_OUT  = OW'(MAX_OUTSTANDING);
  localparam logic [XW-1:0]         X_LAST   = XW'(BLOCK_W - 1);
  localparam logic [YW-1:0]         Y_LAST   = YW'(BLOCK_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t state, state_n;

  // Latched frame configuration
  logic [15:0]           blocks_x_m1, blocks_y_m1;
  logic [ADDR_WIDTH-1:0] stride_q, row_step, base_q;

  // AR issue side
  logic [YW-1:0]         ar_line;
  logic [15:0]           ar_col, ar_row;
  logic [ADDR_WIDTH-1:0] line_addr, blk_addr, row_addr;

  // R tracking side
  logic [XW-1:0]         px;
  logic [YW-1:0]         py;
  logic [15:0]           bc, br;
  logic                  got_beat;

  logic [OW-1:0]         out_cnt;

  logic width_bad, height_bad, stride_bad, cfg_ok;
  logic start_ok, start_bad;
  logic ar_hs, last_line, last_col, last_row, last_burst;
  logic px_last, py_last, bc_last, rlast_beat;

  // Config check: power-of-2 block sizes make the modulus a low-bit test.
  always_comb begin
    width_bad  = (|frame_width[XW-1:0])  || (frame_width  == '0);
    height_bad = (|frame_height[YW-1:0]) || (frame_height == '0);
    stride_bad = {2'b00, line_stride} < ({2'b00, frame_width} << BPP_SH);
    cfg_ok     = !width_bad && !height_bad && !stride_bad;
    start_ok   = (state == IDLE) && frame_ready && cfg_ok;
    start_bad  = (state == IDLE) && frame_ready && !cfg_ok;
  end

  always_comb begin
    last_line  = (ar_line == Y_LAST);
    last_col   = (ar_col == blocks_x_m1);
    last_row   = (ar_row == blocks_y_m1);
    last_burst = last_line && last_col && last_row;
    ar_hs      = arvalid && arready;
  end

  always_comb begin
    px_last    = (px == X_LAST);
    py_last    = (py == Y_LAST);
    bc_last    = (bc == blocks_x_m1);
    rlast_beat = pixel_valid && rlast;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    arvalid = 1'b0;
    rready  = 1'b0;
    busy    = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_n = RUN;
      end
      RUN: begin
        arvalid = (out_cnt < MAX_OUT);
        rready  = 1'b1;
        if (ar_hs && last_burst) state_n = DRAIN;
      end
      DRAIN: begin
        rready = 1'b1;
        if (out_cnt == '0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blocks_x_m1 <= '0;
      blocks_y_m1 <= '0;
      stride_q    <= '0;
      row_step    <= '0;
      base_q      <= '0;
    end else if (start_ok) begin
      blocks_x_m1 <= (frame_width >> XW) - 16'd1;
      blocks_y_m1 <= (frame_height >> YW) - 16'd1;
      stride_q    <= ADDR_WIDTH'(line_stride);
      row_step    <= ADDR_WIDTH'(line_stride) << YW;
      base_q      <= base_addr_in;
    end
  end

  // Three running bases replace the x/y multiply: each wrap reloads the finer
  // base from the coarser one plus its step.
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_line   <= '0;
      ar_col    <= '0;
      ar_row    <= '0;
      line_addr <= '0;
      blk_addr  <= '0;
      row_addr  <= '0;
    end else if (start_ok) begin
      ar_line   <= '0;
      ar_col    <= '0;
      ar_row    <= '0;
      line_addr <= base_addr_in;
      blk_addr  <= base_addr_in;
      row_addr  <= base_addr_in;
    end else if (ar_hs) begin
      if (!last_line) begin
        ar_line   <= ar_line + YW'(1);
        line_addr <= line_addr + stride_q;
      end else begin
        ar_line <= '0;
        if (!last_col) begin
          ar_col    <= ar_col + 16'd1;
          blk_addr  <= blk_addr + BLK_STEP;
          line_addr <= blk_addr + BLK_STEP;
        end else begin
          ar_col    <= '0;
          ar_row    <= ar_row + 16'd1;
          row_addr  <= row_addr + row_step;
          blk_addr  <= row_addr + row_step;
          line_addr <= row_addr + row_step;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      out_cnt <= '0;
    end else begin
      case ({ar_hs, rlast_beat && (out_cnt != '0)})
        2'b10:   out_cnt <= out_cnt + OW'(1);
        2'b01:   out_cnt <= out_cnt - OW'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      px       <= '0;
      py       <= '0;
      bc       <= '0;
      br       <= '0;
      got_beat <= 1'b0;
    end else if (pixel_valid) begin
      got_beat <= 1'b1;
      if (!px_last) begin
        px <= px + XW'(1);
      end else begin
        px <= '0;
        if (!py_last) begin
          py <= py + YW'(1);
        end else begin
          py <= '0;
          if (bc_last) begin
            bc <= '0;
            br <= br + 16'd1;
          end else begin
            bc <= bc + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done    <= 1'b0;
      base_addr_out <= '0;
      cfg_error     <= 1'b0;
    end else begin
      frame_done <= (state_n == DONE);
      if (state_n == DONE) base_addr_out <= base_q;
      if (start_ok)
        cfg_error <= 1'b0;
      else if (start_bad || (pixel_valid && (rlast != px_last)))
        cfg_error <= 1'b1;
    end
  end

  always_comb begin
    araddr         = line_addr;
    arlen          = 8'(BLOCK_W - 1);
    arsize         = 3'(BPP_SH);
    arburst        = 2'b01;
    pixel_valid    = rvalid && rready;
    pixel_x        = 6'(px);
    pixel_y        = 6'(py);
    block_col      = bc;
    block_row      = br;
    start_of_frame = pixel_valid && (px == '0) && (py == '0) && (bc == '0) && (br == '0) && !got_beat;
    end_of_block   = pixel_valid && px_last && py_last;
  end

endmodule

// File: tb/tb_block_raster_reader.sv
// Bench for block_raster_reader: an AXI slave with random ready/valid timing, checked
// against expected burst addresses and beat tags computed arithmetically from the frame geometry.
module tb_block_raster_reader;

  localparam int unsigned AW   = 32;
  localparam int unsigned BW   = 8;
  localparam int unsigned BH   = 8;
  localparam int unsigned BPP  = 2;
  localparam int unsigned MAXO = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_ready = 1'b0;
  logic [15:0]   frame_width = '0, frame_height = '0, line_stride = '0;
  logic [AW-1:0] base_addr_in = '0;
  logic          arvalid, arready = 1'b0, rvalid = 1'b0, rlast = 1'b0, rready;
  logic [AW-1:0] araddr, base_addr_out;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          pixel_valid, start_of_frame, end_of_block, frame_done, busy, cfg_error;
  logic [5:0]    pixel_x, pixel_y;
  logic [15:0]   block_col, block_row;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  block_raster_reader #(
    .ADDR_WIDTH(AW), .BLOCK_W(BW), .BLOCK_H(BH), .BPP(BPP), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .frame_ready(frame_ready),
    .frame_width(frame_width), .frame_height(frame_height), .line_stride(line_stride),
    .base_addr_in(base_addr_in),
    .arvalid(arvalid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arready(arready), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .pixel_valid(pixel_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .block_col(block_col), .block_row(block_row),
    .start_of_frame(start_of_frame), .end_of_block(end_of_block),
    .frame_done(frame_done), .base_addr_out(base_addr_out),
    .busy(busy), .cfg_error(cfg_error)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start address of burst b: block row/col and line picked apart by plain arithmetic.
  function automatic logic [AW-1:0] burst_addr(input int unsigned b, input int unsigned bx,
                                               input int unsigned stride, input logic [AW-1:0] base);
    int unsigned ln  = b % BH;
    int unsigned blk = b / BH;
    return AW'(base + ((blk / bx) * BH + ln) * stride + (blk % bx) * BW * BPP);
  endfunction

  task automatic reset_check();
    rvalid = 1'b1; rlast = 1'b1; arready = 1'b1;
    #1;
    chk("rst_arvalid",   64'(arvalid), 64'(0));
    chk("rst_araddr",    64'(araddr), 64'(0));
    chk("rst_rready",    64'(rready), 64'(0));
    chk("rst_pixel_valid", 64'(pixel_valid), 64'(0));
    chk("rst_pixel_xy",  64'({pixel_x, pixel_y}), 64'(0));
    chk("rst_block",     64'({block_col, block_row}), 64'(0));
    chk("rst_sof_eob",   64'({start_of_frame, end_of_block}), 64'(0));
    chk("rst_frame_done", 64'(frame_done), 64'(0));
    chk("rst_base_out",  64'(base_addr_out), 64'(0));
    chk("rst_busy",      64'(busy), 64'(0));
    chk("rst_cfg_error", 64'(cfg_error), 64'(0));
    chk("arlen",   64'(arlen), 64'(BW - 1));
    chk("arsize",  64'(arsize), 64'(1));
    chk("arburst", 64'(arburst), 64'(1));
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
  endtask

  task automatic reject_start(input string tag, input int unsigned w, input int unsigned h,
                              input int unsigned stride);
    @(negedge clk);
    frame_width = 16'(w); frame_height = 16'(h); line_stride = 16'(stride);
    base_addr_in = 32'h5000; frame_ready = 1'b1; arready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    #1;
    chk({tag, "_cfg_error"}, 64'(cfg_error), 64'(1));
    chk({tag, "_busy"},      64'(busy), 64'(0));
    chk({tag, "_arvalid"},   64'(arvalid), 64'(0));
    @(negedge clk);
    #1;
    chk({tag, "_arvalid_later"}, 64'(arvalid), 64'(0));
    arready = 1'b0;
  endtask

  // One frame against a randomly timed slave. ar_hold/r_hold keep arready/rvalid low for the
  // first cycles; abort_beats>0 stops after that many beats (caller resets); spurious pulses
  // an invalid frame_ready mid-frame, which must be ignored.
  task automatic run_frame(input int unsigned w, input int unsigned h, input int unsigned stride,
                           input logic [AW-1:0] base, input int unsigned ar_p, input int unsigned r_p,
                           input int unsigned ar_hold, input int unsigned r_hold,
                           input int unsigned abort_beats, input bit spurious);
    int unsigned bx = w / BW;
    int unsigned total = (w / BW) * (h / BH) * BH;
    int unsigned total_beats = total * BW;
    int unsigned issued = 0, beats = 0, done_b = 0, pulses = 0, hs_early = 0;
    int unsigned b, px, ln, blk;
    bit rv, exp_arv, finished = 1'b0;
    @(negedge clk);
    frame_width = 16'(w); frame_height = 16'(h); line_stride = 16'(stride);
    base_addr_in = base; frame_ready = 1'b1; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    @(negedge clk);
    frame_ready = 1'b0;
    #1;
    chk("start_cfg_error", 64'(cfg_error), 64'(0));
    chk("start_busy", 64'(busy), 64'(1));
    for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
      if (spurious && cyc == 5) begin
        frame_ready = 1'b1; frame_width = 16'd20; base_addr_in = 32'hDEAD0000;
      end else if (spurious && cyc == 6) begin
        frame_ready = 1'b0; frame_width = 16'(w); base_addr_in = base;
      end
      arready = (cyc >= int'(ar_hold)) && ($urandom_range(99) < ar_p);
      rv = (cyc >= int'(r_hold)) && (issued * BW > beats) && ($urandom_range(99) < r_p);
      rvalid = rv;
      rlast = rv && (beats % BW == BW - 1);
      #1;
      if (frame_done) begin
        pulses++;
        chk("done_all_beats", 64'(beats), 64'(total_beats));
        chk("done_base_out", 64'(base_addr_out), 64'(base));
        chk("done_busy", 64'(busy), 64'(1));
        finished = 1'b1;
      end else begin
        chk("busy", 64'(busy), 64'(1));
        chk("cfg_error", 64'(cfg_error), 64'(0));
        exp_arv = (issued < total) && (issued - done_b < MAXO);
        chk("arvalid", 64'(arvalid), 64'(exp_arv));
        if (exp_arv) chk("araddr", 64'(araddr), 64'(burst_addr(issued, bx, stride, base)));
        chk("pixel_valid", 64'(pixel_valid), 64'(rv));
        if (rv) begin
          b = beats / BW; px = beats % BW; ln = b % BH; blk = b / BH;
          chk("pixel_x", 64'(pixel_x), 64'(px));
          chk("pixel_y", 64'(pixel_y), 64'(ln));
          chk("block_col", 64'(block_col), 64'(blk % bx));
          chk("block_row", 64'(block_row), 64'(blk / bx));
          chk("start_of_frame", 64'(start_of_frame), 64'(beats == 0));
          chk("end_of_block", 64'(end_of_block), 64'(px == BW - 1 && ln == BH - 1));
        end
      end
      if (cyc < int'(r_hold) && arvalid && arready) hs_early++;
      if (exp_arv && arready) issued++;
      if (rv) begin
        if (rlast) done_b++;
        beats++;
      end
      if (abort_beats != 0 && beats == abort_beats) break;
      @(negedge clk);
    end
    rvalid = 1'b0; rlast = 1'b0; arready = 1'b0;
    if (abort_beats == 0) begin
      chk("frame_finished", 64'(finished), 64'(1));
      #1;
      chk("frame_done_pulses", 64'(pulses), 64'(1));
      chk("frame_done_clear", 64'(frame_done), 64'(0));
      chk("busy_idle", 64'(busy), 64'(0));
      chk("base_out_hold", 64'(base_addr_out), 64'(base));
    end
    if (r_hold >= 20 && ar_p == 100) chk("outstanding_cap", 64'(hs_early), 64'(MAXO));
  endtask

  int unsigned rw, rh, rs;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    reset_check();

    reject_start("w20", 20, 16, 64);
    reject_start("h12", 16, 12, 64);
    reject_start("stride_small", 16, 16, 31);

    // 2x2 blocks, full-rate slave; block 1 starts at 0x10, block row 1 at 0x200
    run_frame(16, 16, 64, 32'h0, 100, 100, 0, 0, 0, 1'b0);
    // rvalid held off: only MAXO bursts may issue
    run_frame(16, 16, 32, 32'h1000, 100, 100, 0, 20, 0, 1'b0);
    // arready held off: araddr must hold on burst 0
    run_frame(16, 16, 32, 32'h2000, 100, 100, 5, 0, 0, 1'b0);
    // ragged timing plus an ignored start pulse mid-frame
    run_frame(32, 24, 80, $urandom, 60, 70, 0, 0, 0, 1'b1);

    // abort after the 10th beat
    run_frame(16, 16, 40, 32'h3000, 100, 100, 0, 0, 10, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    reset_check();
    repeat (4) begin
      @(negedge clk);
      #1;
      chk("no_ar_after_reset", 64'(arvalid), 64'(0));
      chk("idle_after_reset", 64'(busy), 64'(0));
    end
    run_frame(16, 16, 40, 32'h3000, 100, 100, 0, 0, 0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      rw = BW * $urandom_range(2, 4);
      rh = BH * $urandom_range(2, 3);
      rs = rw * BPP + $urandom_range(0, 40);
      run_frame(rw, rh, rs, $urandom, $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, 0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
